// File: rtl/upc_checkout.sv
// upc_checkout: edge-triggered UPC scan classifier with saturating item/discount counts and stolen alarm.
// Define UPC_STOLEN_LATCH_EN to latch the stolen alarm in an ALARM state until clear.
module upc_checkout #(
  parameter int UPC_W = 3,
  parameter int CNT_W = 4,
  parameter logic [2**UPC_W-1:0] DISC_MASK = 8'b0010_0011,
  parameter logic [2**UPC_W-1:0] EXP_MASK = 8'b1100_0010
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scan,
  input  logic             clear,
  input  logic [UPC_W-1:0] upc,
  input  logic             mark,
  output logic [UPC_W-1:0] last_upc,
  output logic             discounted,
  output logic             stolen,
  output logic [CNT_W-1:0] item_count,
  output logic [CNT_W-1:0] disc_count,
  output logic             scan_valid,
  output logic             alarm_state
);
  typedef enum logic [1:0] {IDLE, ACTIVE, ALARM} state_t;
  state_t state;
  logic scan_d, scan_edge, disc, theft, accept;
  assign scan_edge = scan & ~scan_d;
  assign disc = DISC_MASK[upc];
  assign theft = EXP_MASK[upc] & ~mark;
  assign accept = scan_edge & ~clear & (state != ALARM);
  // scan_d resets high so a strobe held through reset is not taken as a scan
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      scan_d <= 1'b1;
      last_upc <= '0;
      discounted <= 1'b0;
      stolen <= 1'b0;
      item_count <= '0;
      disc_count <= '0;
      scan_valid <= 1'b0;
    end else begin
      scan_d <= scan;
      scan_valid <= 1'b0;
      if (clear) begin
        state <= IDLE;
        last_upc <= '0;
        discounted <= 1'b0;
        stolen <= 1'b0;
        item_count <= '0;
        disc_count <= '0;
      end else if (accept) begin
        last_upc <= upc;
        discounted <= disc;
        stolen <= theft;
        item_count <= item_count + CNT_W'(item_count != '1);
        disc_count <= disc_count + CNT_W'(disc && disc_count != '1);
        scan_valid <= 1'b1;
`ifdef UPC_STOLEN_LATCH_EN
        state <= theft ? ALARM : ACTIVE;
`else
        state <= ACTIVE;
`endif
      end
    end
  end
`ifdef UPC_STOLEN_LATCH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) alarm_state <= 1'b0;
    else if (clear) alarm_state <= 1'b0;
    else if (accept) alarm_state <= theft;
  end
`else
  assign alarm_state = 1'b0;
`endif
endmodule

// File: tb/tb_upc_checkout.sv
// tb_upc_checkout: table vectors, directed corner sequences and a random run against a behavioural model.
module tb_upc_checkout;
`ifdef UPC_STOLEN_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif
  logic clk = 0, reset_n = 0, scan = 1, clear = 0, mark = 0;
  logic [2:0] upc = 0;
  logic [2:0] last_upc;
  logic discounted, stolen, scan_valid, alarm_state;
  logic [3:0] item_count, disc_count;
  logic [7:0] dmask = 8'b0010_0011, emask = 8'b1100_0010;
  int n_vec = 0, n_err = 0;
  int m_items, m_disc, m_last;
  bit m_dsc, m_st, m_val, m_alarm, m_prev;

  upc_checkout dut (.clk(clk), .reset_n(reset_n), .scan(scan), .clear(clear), .upc(upc), .mark(mark),
    .last_upc(last_upc), .discounted(discounted), .stolen(stolen), .item_count(item_count),
    .disc_count(disc_count), .scan_valid(scan_valid), .alarm_state(alarm_state));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sat(int v);
    return v > 15 ? 15 : v;
  endfunction

  function automatic void model_step(bit s, bit c, int u, bit mk);
    bit e = s && !m_prev;
    m_prev = s;
    m_val = 0;
    if (c) begin
      {m_items, m_disc, m_last} = '0;
      {m_dsc, m_st, m_alarm} = '0;
    end else if (e && !m_alarm) begin
      m_last = u;
      m_dsc = dmask[u];
      m_st = emask[u] && !mk;
      m_items = sat(m_items + 1);
      m_disc = sat(m_disc + int'(m_dsc));
      m_val = 1;
      m_alarm = LATCH && m_st;
    end
  endfunction

  task automatic check_all(string t, int items, int disc, int last, bit dsc, bit st, bit val, bit alm);
    chk({t, " item_count"}, item_count, items);
    chk({t, " disc_count"}, disc_count, disc);
    chk({t, " last_upc"}, last_upc, last);
    chk({t, " discounted"}, discounted, dsc);
    chk({t, " stolen"}, stolen, st);
    chk({t, " scan_valid"}, scan_valid, val);
    chk({t, " alarm_state"}, alarm_state, alm);
  endtask

  task automatic pulse(bit c, logic [2:0] u, bit mk);
    scan = 1; clear = c; upc = u; mark = mk;
    @(posedge clk); #1;
    scan = 0; clear = 0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit clr; logic [2:0] u; bit mk;
    int items, disc, last; bit dsc, st, val, alm;
  } vec_t;
  vec_t tbl[$];

  initial begin
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 5, 0, 1, 1, 5, 1, 0, 1, 0});
    tbl.push_back('{0, 2, 0, 2, 1, 2, 0, 0, 1, 0});
    tbl.push_back('{0, 7, 1, 3, 1, 7, 0, 0, 1, 0});
    tbl.push_back('{0, 1, 1, 4, 2, 1, 1, 0, 1, 0});
    tbl.push_back('{0, 3, 0, 5, 2, 3, 0, 0, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 6, 1, 1, 0, 6, 0, 0, 1, 0});
    tbl.push_back('{0, 6, 0, 2, 0, 6, 0, 1, 1, LATCH});
    tbl.push_back('{0, 0, 0, LATCH ? 2 : 3, LATCH ? 0 : 1, LATCH ? 6 : 0, !LATCH, LATCH, !LATCH, LATCH});
    tbl.push_back('{0, 1, 0, LATCH ? 2 : 4, LATCH ? 0 : 2, LATCH ? 6 : 1, !LATCH, 1, !LATCH, LATCH});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0});

    // reset with scan held high, then release while still high
    repeat (2) @(posedge clk);
    #1 check_all("reset", 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("held_scan scan_valid", scan_valid, 0);
      chk("held_scan item_count", item_count, 0);
    end
    scan = 0;
    @(posedge clk); #1;
    scan = 1; upc = 0; mark = 0;
    @(posedge clk); #1;
    check_all("first_scan", 1, 1, 0, 1, 0, 1, 0);
    scan = 0;
    @(posedge clk); #1;
    chk("first_scan pulse_end", scan_valid, 0);

    foreach (tbl[i]) begin
      scan = 1; clear = tbl[i].clr; upc = tbl[i].u; mark = tbl[i].mk;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), tbl[i].items, tbl[i].disc, tbl[i].last,
                tbl[i].dsc, tbl[i].st, tbl[i].val, tbl[i].alm);
      scan = 0; clear = 0;
      @(posedge clk); #1;
      chk($sformatf("vec%0d valid_drop", i), scan_valid, 0);
    end

    // saturation
    repeat (17) pulse(0, 5, 0);
    chk("sat item_count", item_count, 15);
    chk("sat disc_count", disc_count, 15);

    // asynchronous reset between edges
    pulse(1, 0, 0);
    repeat (3) pulse(0, 0, 0);
    #2 reset_n = 0;
    #1 check_all("async_reset", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 reset_n = 1;

    // random run against the model
    clear = 1; scan = 0;
    @(posedge clk); #1;
    model_step(0, 1, 0, 0);
    for (int k = 0; k < 800; k++) begin
      scan = 1'($urandom_range(0, 1));
      clear = $urandom_range(0, 59) == 0;
      upc = 3'($urandom_range(0, 7));
      mark = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_step(scan, clear, int'(upc), mark);
      #1 check_all($sformatf("rand%0d", k), m_items, m_disc, m_last, m_dsc, m_st, m_val, m_alarm);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/upc_checkout.md
# upc_checkout

Sequential, parametrised successor to the combinational UPC checker. It accepts a stream of item scans (UPC code plus "marked" bit) on rising edges of a scan strobe and classifies each item as discounted or stolen from parameter masks. It also keeps saturating item and discount counts for the current transaction and raises a stolen alarm. It sits between debounced board inputs (switches/keys) and the LED / seven-segment display logic on the DE1-SoC top level.

## Interface
Parameters:
- UPC_W, 3, width of UPC code
- CNT_W, 4, width of item/discount counters
- DISC_MASK, 8'b0010_0011, width 2**UPC_W; bit i set = code i is discounted
- EXP_MASK, 8'b1100_0010, width 2**UPC_W; bit i set = code i is expensive (must be marked)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- scan  in  1  scan strobe, level, already synchronised; one scan per 0->1 transition
- clear  in  1  synchronous end-of-transaction; zeroes counts and alarm
- upc  in  UPC_W  code of item being scanned
- mark  in  1  item carries the paid/marked tag
- last_upc  out  UPC_W  code of last accepted scan
- discounted  out  1  last accepted item is discounted
- stolen  out  1  stolen alarm
- item_count  out  CNT_W  accepted scans since clear, saturating
- disc_count  out  CNT_W  accepted discounted scans since clear, saturating
- scan_valid  out  1  one-cycle pulse per accepted scan
- alarm_state  out  1  FSM in ALARM

## Operation
- Edge detect: register scan_d; scan_edge = scan & ~scan_d. scan_d resets to 1, so a strobe held high through reset never produces a scan.
- Classification on scan_edge: disc = DISC_MASK[upc]; theft = EXP_MASK[upc] & ~mark.
- FSM states: IDLE (no items since clear/reset), ACTIVE (>=1 item), ALARM (stolen latched).
  - IDLE/ACTIVE + scan_edge & ~theft -> ACTIVE.
  - IDLE/ACTIVE + scan_edge & theft -> ALARM.
  - ALARM: scan_edge ignored (no count, no scan_valid, outputs frozen).
  - Any state + clear -> IDLE.
- On accepted scan: last_upc<=upc, discounted<=disc, stolen<=theft (sticky in ALARM), item_count+=1, disc_count+=disc, scan_valid<=1. The stolen item is counted.
- Counters saturate at 2**CNT_W-1 and do not wrap.
- clear and scan_edge in the same cycle: clear wins. The edge is consumed (scan_d updates), counts/last_upc/discounted/stolen go to 0, and scan_valid stays 0.
- Reset values: state IDLE, last_upc 0, discounted 0, stolen 0, item_count 0, disc_count 0, scan_valid 0, alarm_state 0, scan_d 1.
- reset_n low mid-transaction clears everything immediately (asynchronously), regardless of clk.

## Timing
- Inputs sampled at rising clk edge k. If the scan edge is seen at k, every output reflects that scan after edge k (one-cycle registered latency).
- scan_valid is high for exactly the cycle after edge k. Back-to-back scans need scan low for at least 1 sampled cycle between them.
- clear takes effect at the edge where it is sampled high. Holding clear high keeps the block in IDLE and rejects scans.
- upc and mark need only be valid at the edge where the scan transition is sampled.
- All outputs are driven directly from flops; there is no combinational input-to-output path.

## Configuration
- Macro UPC_STOLEN_LATCH_EN.
- Defined: behaviour above. ALARM is sticky until clear, and scans are rejected while in ALARM.
- Undefined: ALARM state is not built and alarm_state is tied 0. stolen <= theft of each accepted scan, so it is non-sticky and follows the last item. A theft scan moves the FSM to ACTIVE, and scanning continues normally.

## Test plan
- Hold scan=1 during reset, then release reset_n with scan still 1 -> no scan_valid, item_count=0. Drop scan then raise it with upc=0, mark=0 -> one scan, item_count=1.
- From IDLE, scan upc=0, mark=0 -> after 1 cycle: discounted=1, stolen=0, item_count=1, disc_count=1, last_upc=0, scan_valid high exactly 1 cycle.
- With the latch macro defined: scan upc=6, mark=0 -> stolen=1, alarm_state=1, item_count=1. Scan upc=0 -> item_count stays 1, no scan_valid. Assert clear -> all outputs 0, state IDLE. Without the macro, the second scan counts (item_count=2) and stolen=0.
- Scan upc=6, mark=1 -> stolen=0, discounted=0, item_count=1, disc_count=0.
- 17 scans of upc=5 -> item_count=15, disc_count=15 (saturated, no wrap).
- Raise clear in the same cycle as a scan edge (upc=0) after 3 items -> item_count=0, disc_count=0, scan_valid never asserted. Pulse reset_n low mid-transaction between clk edges -> outputs 0 before the next edge.
